eth_burst_seq: RTL and testbench

ETH_BURST_SEQ -- requirements
Module: eth_burst_seq

---
 rtl/eth_burst_seq_if.sv | 32 +++
 rtl/eth_burst_seq.sv | 184 ++++++++++++++++++
 tb/tb_eth_burst_seq.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_burst_seq_if.sv
// Burst sequencer bus: requester start/done, burst parameters, FIFO-fill and MAC-transmit handshakes.
// master = requester/environment side, slave = eth_burst_seq.
interface eth_burst_seq_if #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned GAP_W = 8
);
   localparam int unsigned LEN_W = 16;

   logic             fs;
   logic             fd;
   logic [CNT_W-1:0] pkt_num;
   logic [LEN_W-1:0] tx_dlen;
   logic [GAP_W-1:0] gap_len;
   logic             fs_fifo;
   logic             fd_fifo;
   logic             fs_eth;
   logic             fd_eth;
   logic [LEN_W-1:0] udp_tx_dlen;
   logic [LEN_W-1:0] ip_tx_dlen;
   logic [CNT_W-1:0] pkt_idx;
   logic             busy;

   modport master (
      output fs, pkt_num, tx_dlen, gap_len, fd_fifo, fd_eth,
      input  fd, fs_fifo, fs_eth, udp_tx_dlen, ip_tx_dlen, pkt_idx, busy
   );

   modport slave (
      input  fs, pkt_num, tx_dlen, gap_len, fd_fifo, fd_eth,
      output fd, fs_fifo, fs_eth, udp_tx_dlen, ip_tx_dlen, pkt_idx, busy
   );
endinterface

// File: rtl/eth_burst_seq.sv
// Ethernet burst sequencer: fills the payload FIFO, then sends pkt_num UDP frames separated by gap_len idle cycles.
// Optional macro BURST_SEQ_REFILL_EN: when defined, the payload FIFO is refilled before every packet.
module eth_burst_seq #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned GAP_W = 8
) (
   input  logic           clk,
   input  logic           rst,
   eth_burst_seq_if.slave bus
);
   localparam int unsigned LEN_W   = 16;
   localparam int unsigned UDP_HDR = 8;
   localparam int unsigned IP_HDR  = 28;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FIFO,
      S_SEND,
      S_GAP,
      S_DONE
   } state_t;

`ifdef BURST_SEQ_REFILL_EN
   localparam state_t GAP_EXIT = S_FIFO;
`else
   localparam state_t GAP_EXIT = S_SEND;
`endif

   state_t state_q, state_nx;

   logic [CNT_W-1:0] pkt_num_q;
   logic [LEN_W-1:0] tx_dlen_q;
   logic [GAP_W-1:0] gap_len_q;
   logic [GAP_W-1:0] gap_cnt_q;

   logic             fd_q;
   logic             fs_fifo_q;
   logic             fs_eth_q;
   logic             busy_q;
   logic [CNT_W-1:0] pkt_idx_q;
   logic [LEN_W-1:0] udp_len_q;
   logic [LEN_W-1:0] ip_len_q;

   logic latch_en;
   logic load_en;
   logic gap_start;
   logic idx_inc;
   logic last_pkt_c;
   logic gap_done_c;

   // pkt_num_q is non-zero whenever SEND is reached, so the subtraction never wraps there
   assign last_pkt_c = (pkt_idx_q == CNT_W'(pkt_num_q - CNT_W'(1)));
   assign gap_done_c = (gap_cnt_q <= GAP_W'(1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_nx;
      end
   end

   // Next-state and datapath strobes
   always_comb begin
      state_nx  = state_q;
      latch_en  = 1'b0;
      load_en   = 1'b0;
      gap_start = 1'b0;
      idx_inc   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.fs) begin
               latch_en = 1'b1;
               state_nx = S_LOAD;
            end
         end
         S_LOAD: begin
            load_en  = 1'b1;
            state_nx = (pkt_num_q == '0) ? S_DONE : S_FIFO;
         end
         S_FIFO: begin
            if (bus.fd_fifo) begin
               state_nx = S_SEND;
            end
         end
         S_SEND: begin
            if (bus.fd_eth) begin
               if (last_pkt_c) begin
                  state_nx = S_DONE;
               end else begin
                  gap_start = 1'b1;
                  state_nx  = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (gap_done_c) begin
               idx_inc  = 1'b1;
               state_nx = GAP_EXIT;
            end
         end
         S_DONE: begin
            if (!bus.fs) begin
               state_nx = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Burst parameters captured at start so later input changes cannot disturb the burst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_num_q <= '0;
         tx_dlen_q <= '0;
         gap_len_q <= '0;
      end else if (latch_en) begin
         pkt_num_q <= bus.pkt_num;
         tx_dlen_q <= bus.tx_dlen;
         gap_len_q <= bus.gap_len;
      end
   end

   // Inter-packet gap down-counter; a zero gap still idles fs_eth for one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gap_cnt_q <= '0;
      end else if (gap_start) begin
         gap_cnt_q <= (gap_len_q == '0) ? GAP_W'(1) : gap_len_q;
      end else if ((state_q == S_GAP) && !gap_done_c) begin
         gap_cnt_q <= gap_cnt_q - GAP_W'(1);
      end
   end

   // Registered outputs decoded from the next state, so each equals its state decode glitch-free
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fd_q      <= 1'b0;
         fs_fifo_q <= 1'b0;
         fs_eth_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         fd_q      <= (state_nx == S_DONE);
         fs_fifo_q <= (state_nx == S_FIFO);
         fs_eth_q  <= (state_nx == S_SEND);
         busy_q    <= (state_nx != S_IDLE);
      end
   end

   // Header length fields wrap modulo 2^16
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         udp_len_q <= '0;
         ip_len_q  <= '0;
      end else if (load_en) begin
         udp_len_q <= tx_dlen_q + LEN_W'(UDP_HDR);
         ip_len_q  <= tx_dlen_q + LEN_W'(IP_HDR);
      end
   end

   // Packet index; peaks at pkt_num-1 so it never overflows CNT_W
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_idx_q <= '0;
      end else if (load_en) begin
         pkt_idx_q <= '0;
      end else if (idx_inc) begin
         pkt_idx_q <= pkt_idx_q + CNT_W'(1);
      end
   end

   assign bus.fd          = fd_q;
   assign bus.fs_fifo     = fs_fifo_q;
   assign bus.fs_eth      = fs_eth_q;
   assign bus.busy        = busy_q;
   assign bus.pkt_idx     = pkt_idx_q;
   assign bus.udp_tx_dlen = udp_len_q;
   assign bus.ip_tx_dlen  = ip_len_q;

endmodule

// File: tb/tb_eth_burst_seq.sv
// Self-checking bench for eth_burst_seq: per-packet scoreboard plus end-of-burst counts and latency.
// FIFO and MAC responders answer after three cycles and inject spurious fd pulses in the wrong states.
module tb_eth_burst_seq;
   localparam int unsigned CNT_W    = 8;
   localparam int unsigned GAP_W    = 8;
   localparam int          RESP_DLY = 3;

`ifdef BURST_SEQ_REFILL_EN
   localparam bit REFILL = 1'b1;
`else
   localparam bit REFILL = 1'b0;
`endif

   typedef struct packed {
      logic [CNT_W-1:0] idx;
      logic [15:0]      udp;
      logic [15:0]      ip;
      logic             fifo_before;
      logic [15:0]      low;
   } rec_t;

   logic clk;
   logic rst;

   eth_burst_seq_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

   eth_burst_seq #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   n_cmp;
   int   n_bad;
   rec_t sb_q[$];
   int   fifo_pulses;
   int   eth_pulses;
   int   low_cnt;
   bit   fifo_seen;
   bit   prev_eth;
   bit   prev_fifo;
   int   fc;
   int   ec;
   rec_t mon_r;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // FIFO / MAC responders, plus spurious done pulses while the other handshake is active
   initial begin
      fc = 0;
      ec = 0;
      bus.fd_fifo = 1'b0;
      bus.fd_eth  = 1'b0;
      forever begin
         @(negedge clk);
         bus.fd_fifo = 1'b0;
         bus.fd_eth  = 1'b0;
         if (rst) begin
            fc = 0;
            ec = 0;
         end else begin
            if (bus.fs_fifo) begin
               if (fc == RESP_DLY - 1) begin
                  bus.fd_fifo = 1'b1;
                  fc = 0;
               end else begin
                  fc++;
               end
            end else begin
               fc = 0;
            end
            if (bus.fs_eth) begin
               if (ec == RESP_DLY - 1) begin
                  bus.fd_eth = 1'b1;
                  ec = 0;
               end else begin
                  ec++;
               end
            end else begin
               ec = 0;
            end
            if (bus.fs_fifo) bus.fd_eth  = 1'b1;
            if (bus.fs_eth)  bus.fd_fifo = 1'b1;
         end
      end
   end

   // Monitor: every rising fs_eth consumes one scoreboard entry
   initial begin
      prev_eth  = 1'b0;
      prev_fifo = 1'b0;
      low_cnt   = 0;
      fifo_seen = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_eth  = 1'b0;
            prev_fifo = 1'b0;
            low_cnt   = 0;
            fifo_seen = 1'b0;
         end else begin
            if (bus.fs_fifo && !prev_fifo) begin
               fifo_pulses++;
               fifo_seen = 1'b1;
            end
            if (bus.fs_eth && !prev_eth) begin
               eth_pulses++;
               if (sb_q.size() > 0) begin
                  mon_r = sb_q.pop_front();
                  chk_val("pkt_idx", 32'(bus.pkt_idx), 32'(mon_r.idx));
                  chk_val("udp_len_pkt", 32'(bus.udp_tx_dlen), 32'(mon_r.udp));
                  chk_val("ip_len_pkt", 32'(bus.ip_tx_dlen), 32'(mon_r.ip));
                  chk_val("fifo_before_eth", 32'(fifo_seen), 32'(mon_r.fifo_before));
                  if (mon_r.idx != '0) chk_val("gap_low_cycles", 32'(low_cnt), 32'(mon_r.low));
               end
               fifo_seen = 1'b0;
               low_cnt   = 0;
            end else if (!bus.fs_eth) begin
               low_cnt++;
            end
            prev_eth  = bus.fs_eth;
            prev_fifo = bus.fs_fifo;
         end
      end
   end

   // Drive burst parameters, raise fs and queue the expected packets
   task automatic start(input int num, input logic [15:0] dlen, input int gap);
      rec_t r;
      int   ge;
      ge = (gap == 0) ? 1 : gap;
      bus.pkt_num = CNT_W'(num);
      bus.tx_dlen = dlen;
      bus.gap_len = GAP_W'(gap);
      fifo_pulses = 0;
      eth_pulses  = 0;
      for (int i = 0; i < num; i++) begin
         r.idx         = CNT_W'(i);
         r.udp         = dlen + 16'd8;
         r.ip          = dlen + 16'd28;
         r.fifo_before = REFILL || (i == 0);
         r.low         = 16'(ge + (REFILL ? RESP_DLY : 0));
         sb_q.push_back(r);
      end
      bus.fs = 1'b1;
   endtask

   // Wait for fd, check burst totals and latency, then complete the four-phase handshake
   task automatic run(input int num, input logic [15:0] dlen, input int gap);
      int cyc;
      int budget;
      int exp_lat;
      int exp_fifo;
      int exp_idx;
      int ge;
      bit done;
      ge       = (gap == 0) ? 1 : gap;
      exp_lat  = (num == 0) ? 2 : 2 + RESP_DLY + RESP_DLY * num + (num - 1) * (ge + (REFILL ? RESP_DLY : 0));
      exp_fifo = (num == 0) ? 0 : (REFILL ? num : 1);
      exp_idx  = (num == 0) ? 0 : num - 1;
      budget   = 60 + num * (20 + gap);
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            chk_val("busy_start", 32'(bus.busy), 32'd1);
            bus.pkt_num = CNT_W'($urandom);
            bus.tx_dlen = 16'($urandom);
            bus.gap_len = GAP_W'($urandom_range(0, 3));
         end
         if (bus.fd) done = 1'b1;
      end
      chk_val("done_seen", 32'(done), 32'd1);
      chk_val("done_latency", 32'(cyc), 32'(exp_lat));
      chk_val("fifo_pulses", 32'(fifo_pulses), 32'(exp_fifo));
      chk_val("eth_pulses", 32'(eth_pulses), 32'(num));
      chk_val("sb_left", 32'(sb_q.size()), 32'd0);
      chk_val("udp_len_done", 32'(bus.udp_tx_dlen), 32'(16'(dlen + 16'd8)));
      chk_val("ip_len_done", 32'(bus.ip_tx_dlen), 32'(16'(dlen + 16'd28)));
      chk_val("pkt_idx_done", 32'(bus.pkt_idx), 32'(exp_idx));
      sb_q.delete();
      repeat (2) @(negedge clk);
      chk_val("fd_hold", 32'(bus.fd), 32'd1);
      bus.fs = 1'b0;
      @(negedge clk);
      chk_val("fd_release", 32'(bus.fd), 32'd0);
      chk_val("busy_release", 32'(bus.busy), 32'd0);
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk_val({tag, "_fd"}, 32'(bus.fd), 32'd0);
      chk_val({tag, "_fs_fifo"}, 32'(bus.fs_fifo), 32'd0);
      chk_val({tag, "_fs_eth"}, 32'(bus.fs_eth), 32'd0);
      chk_val({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk_val({tag, "_pkt_idx"}, 32'(bus.pkt_idx), 32'd0);
      chk_val({tag, "_udp"}, 32'(bus.udp_tx_dlen), 32'd0);
      chk_val({tag, "_ip"}, 32'(bus.ip_tx_dlen), 32'd0);
   endtask

   initial begin
      bit found;
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      bus.fs = 1'b0;
      bus.pkt_num = '0;
      bus.tx_dlen = '0;
      bus.gap_len = '0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      chk_val("idle_busy", 32'(bus.busy), 32'd0);

      start(4, 16'd16, 1);        run(4, 16'd16, 1);
      start(0, 16'h1234, 2);      run(0, 16'h1234, 2);
      start(3, 16'hFFF0, 0);      run(3, 16'hFFF0, 0);
      start(2, 16'd100, 5);       run(2, 16'd100, 5);
      start(1, 16'd0, 3);         run(1, 16'd0, 3);

      // Reset during SEND of packet 2, fs held high through reset
      start(4, 16'd50, 2);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (bus.pkt_idx == CNT_W'(2) && bus.fs_eth) found = 1'b1;
      end
      chk_val("reach_pkt2_send", 32'(found), 32'd1);
      rst = 1'b1;
      #1;
      chk_all_zero("midburst_rst");
      @(negedge clk);
      sb_q.delete();
      start(3, 16'd60, 1);
      rst = 1'b0;
      run(3, 16'd60, 1);

      start(255, 16'd1, 0);       run(255, 16'd1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
